fuzz_capture_replay: RTL and testbench



---
 rtl/fuzz_capture_replay.sv | 232 +++++++++++++++++++++++
 tb/tb_fuzz_capture_replay.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_capture_replay.sv
// Wishbone capture/replay: reads `length` words from the selected source window into a buffer (optionally mutated), then writes them to dst_base.
// Latency 2L+2 cycles start-to-done with a zero-wait slave; slave wait states stall each transfer, bounded by TIMEOUT, abort ends early.
module fuzz_capture_replay #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int IP_NUM            = 4,
    parameter int IP_SELECTOR_WIDTH = 2,
    parameter int DEPTH             = 16,
    parameter int LEN_WIDTH         = $clog2(DEPTH + 1),
    parameter int TIMEOUT           = 255,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY = 32'h80200003
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [IP_SELECTOR_WIDTH-1:0]  ip_selector,
    input  logic [IP_NUM*ADDR_WIDTH-1:0]  src_base_flat,
    input  logic [ADDR_WIDTH-1:0]         dst_base,
    input  logic [LEN_WIDTH-1:0]          length,
    input  logic [DATA_WIDTH-1:0]         lfsr_seed,
    input  logic [DATA_WIDTH-1:0]         corner_case_payload,
    input  logic [LEN_WIDTH-1:0]          corner_index,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    status,
    output logic [LEN_WIDTH-1:0]          words_done,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [ADDR_WIDTH-1:0]         wbm_adr_o,
    output logic [DATA_WIDTH-1:0]         wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0]       wbm_sel_o,
    input  logic [DATA_WIDTH-1:0]         wbm_dat_i,
    input  logic                          wbm_ack_i
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(SEL_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BADCFG  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam logic [1:0] MODE_LFSR    = 2'b01;
    localparam logic [1:0] MODE_CORNER  = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [1:0]             mode_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cidx_q;
    logic [ADDR_WIDTH-1:0]  src_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [ADDR_WIDTH-1:0]  sel_base;
    logic [ADDR_WIDTH-1:0]  offset;
    logic [DATA_WIDTH-1:0]  lfsr;
    logic [DATA_WIDTH-1:0]  lfsr_step;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [TO_W-1:0]        tcnt;
    logic [DATA_WIDTH-1:0]  buffer [DEPTH];
    logic                   cfg_bad;
    logic                   last;
    logic                   stall;
    logic                   rd_we;

    always_comb begin
        sel_base = '0;
        for (int k = 0; k < IP_NUM; k++) begin
            if (ip_selector == IP_SELECTOR_WIDTH'(k)) begin
                sel_base = src_base_flat[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign cfg_bad = (mode == MODE_ILLEGAL)
                  || ({1'b0, ip_selector} >= (IP_SELECTOR_WIDTH + 1)'(IP_NUM))
                  || (length > LEN_WIDTH'(DEPTH));

    assign offset    = ADDR_WIDTH'(words_done) << SHIFT;
    assign last      = (words_done + LEN_WIDTH'(1)) == len_q;
    assign stall     = (tcnt == TO_W'(TIMEOUT - 1));
    assign lfsr_step = {1'b0, lfsr[DATA_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_POLY : '0);
    assign rd_we     = (state == S_READ) && !abort && wbm_ack_i;

    // Mutation is applied on capture so the write phase is a plain replay.
    always_comb begin
        rd_word = wbm_dat_i;
        case (mode_q)
            MODE_LFSR:   rd_word = wbm_dat_i ^ lfsr;
            MODE_CORNER: if (words_done == cidx_q) rd_word = corner_case_payload;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_sel_o = '1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (cfg_bad || length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_adr_o = src_q + offset;
                if (abort) begin
                    state_n = S_DONE;
                end else if (wbm_ack_i) begin
                    if (last) state_n = S_GAP;
                end else if (stall) begin
                    state_n = S_DONE;
                end
            end
            S_GAP: begin
                state_n = abort ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = dst_q + offset;
                wbm_dat_o = buffer[words_done[IDX_W-1:0]];
                if (abort) begin
                    state_n = S_DONE;
                end else if (wbm_ack_i) begin
                    if (last) state_n = S_DONE;
                end else if (stall) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rd_we) begin
            buffer[words_done[IDX_W-1:0]] <= rd_word;
        end
    end

    // Abort takes priority over a same-cycle ack so words_done reflects only completed work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            len_q      <= '0;
            cidx_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            lfsr       <= DATA_WIDTH'(1);
            tcnt       <= '0;
            words_done <= '0;
            status     <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        len_q      <= length;
                        cidx_q     <= corner_index;
                        src_q      <= sel_base;
                        dst_q      <= dst_base;
                        lfsr       <= (lfsr_seed == '0) ? DATA_WIDTH'(1) : lfsr_seed;
                        tcnt       <= '0;
                        words_done <= '0;
                        status     <= cfg_bad ? ST_BADCFG : ST_OK;
                    end
                end
                S_READ, S_WRITE: begin
                    if (abort) begin
                        status <= ST_ABORT;
                    end else if (wbm_ack_i) begin
                        words_done <= words_done + LEN_WIDTH'(1);
                        tcnt       <= '0;
                        if (state == S_READ && mode_q == MODE_LFSR) begin
                            lfsr <= lfsr_step;
                        end
                    end else if (stall) begin
                        status <= ST_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                S_GAP: begin
                    tcnt <= '0;
                    if (abort) begin
                        status <= ST_ABORT;
                    end else begin
                        words_done <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzz_capture_replay.sv
// Directed bench for fuzz_capture_replay: zero-wait Wishbone slave model with a bus monitor, expected transfers queued per step.
module tb_fuzz_capture_replay;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IPN   = 4;
    localparam int IPW   = 2;
    localparam int LW    = 5;
    localparam int TO    = 255;
    localparam logic [31:0] POLY = 32'h80200003;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [IPW-1:0]  ip_selector = '0;
    logic [IPN*AW-1:0] src_base_flat = {32'h0000_7000, 32'h0000_3000, 32'h0000_1000, 32'h0000_5000};
    logic [AW-1:0]   dst_base = '0;
    logic [LW-1:0]   length = '0;
    logic [DW-1:0]   lfsr_seed = '0;
    logic [DW-1:0]   corner_case_payload = '0;
    logic [LW-1:0]   corner_index = '0;
    logic            abort = 1'b0;
    logic            busy;
    logic            done;
    logic [1:0]      status;
    logic [LW-1:0]   words_done;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic [DW-1:0]   wbm_dat_i;
    logic            wbm_ack_i;

    logic [31:0] cur_src = '0;
    logic [31:0] data_base = '0;
    logic [31:0] stall_adr = '0;
    logic        stall_en = 1'b0;

    int total = 0;
    int bad = 0;
    int rd_ptr = 0;
    int wr_ptr = 0;
    int cyc_cnt = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] obs_rd_q[$];
    logic [31:0] obs_wa_q[$];
    logic [31:0] obs_wd_q[$];

    always #5 clk = ~clk;

    fuzz_capture_replay #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IP_NUM(IPN), .IP_SELECTOR_WIDTH(IPW),
        .DEPTH(16), .LEN_WIDTH(LW), .TIMEOUT(TO), .LFSR_POLY(POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ip_selector(ip_selector),
        .src_base_flat(src_base_flat), .dst_base(dst_base), .length(length),
        .lfsr_seed(lfsr_seed), .corner_case_payload(corner_case_payload),
        .corner_index(corner_index), .abort(abort), .busy(busy), .done(done),
        .status(status), .words_done(words_done), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    // Slave returns data_base + word index within the active source window.
    assign wbm_dat_i = data_base + ((wbm_adr_o - cur_src) >> 2);
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !(stall_en && !wbm_we_o && wbm_adr_o == stall_adr);

    always @(negedge clk) begin
        if (wbm_cyc_o) cyc_cnt++;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            if (wbm_we_o) begin
                obs_wa_q.push_back(wbm_adr_o);
                obs_wd_q.push_back(wbm_dat_o);
            end else begin
                obs_rd_q.push_back(wbm_adr_o);
            end
        end
    end

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int len, input logic [1:0] m, input logic [31:0] seed,
                               input logic [31:0] payload, input int cidx);
        logic [31:0] s;
        logic [31:0] w;
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(cur_src + 32'(4 * i));
            w = data_base + 32'(i);
            if (m == 2'b01) begin
                w = w ^ s;
                s = lstep(s);
            end else if (m == 2'b10 && i == cidx) begin
                w = payload;
            end
            exp_wa_q.push_back(dst_base + 32'(4 * i));
            exp_wd_q.push_back(w);
        end
    endtask

    task automatic resync();
        rd_ptr = obs_rd_q.size();
        wr_ptr = obs_wa_q.size();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
    endtask

    task automatic check_bus(input string tag);
        logic [31:0] e;
        chk({tag, ":rd_count"}, 32'(obs_rd_q.size() - rd_ptr), 32'(exp_rd_q.size()));
        chk({tag, ":wr_count"}, 32'(obs_wa_q.size() - wr_ptr), 32'(exp_wa_q.size()));
        while (exp_rd_q.size() > 0) begin
            e = exp_rd_q.pop_front();
            if (rd_ptr < obs_rd_q.size()) chk({tag, ":rd_adr"}, obs_rd_q[rd_ptr], e);
            rd_ptr++;
        end
        while (exp_wa_q.size() > 0) begin
            e = exp_wa_q.pop_front();
            if (wr_ptr < obs_wa_q.size()) chk({tag, ":wr_adr"}, obs_wa_q[wr_ptr], e);
            e = exp_wd_q.pop_front();
            if (wr_ptr < obs_wd_q.size()) chk({tag, ":wr_dat"}, obs_wd_q[wr_ptr], e);
            wr_ptr++;
        end
        rd_ptr = obs_rd_q.size();
        wr_ptr = obs_wa_q.size();
    endtask

    // Called at a negedge; n counts cycles after the start edge (n=0 is the cycle right after it).
    task automatic run_op(input string tag, input int exp_n, input logic [1:0] exp_status,
                          input int exp_words);
        int n;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        chk({tag, ":busy_rise"}, 32'(busy), 32'd1);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":done_cycle"}, 32'(n), 32'(exp_n));
        chk({tag, ":status"}, 32'(status), 32'(exp_status));
        chk({tag, ":words_done"}, 32'(words_done), 32'(exp_words));
        chk({tag, ":cyc_at_done"}, 32'(wbm_cyc_o), 32'd0);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
        chk({tag, ":busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c0;

        repeat (2) @(negedge clk);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst:stb", 32'(wbm_stb_o), 32'd0);
        chk("rst:we", 32'(wbm_we_o), 32'd0);
        chk("rst:adr", wbm_adr_o, 32'd0);
        chk("rst:dat", wbm_dat_o, 32'd0);
        chk("rst:status", 32'(status), 32'd0);
        chk("rst:words", 32'(words_done), 32'd0);
        chk("rst:sel", 32'(wbm_sel_o), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 2'b00; ip_selector = 2'd1; cur_src = 32'h1000; dst_base = 32'h2000;
        length = 5'd4; data_base = 32'hBEEF0000;
        push_expect(4, 2'b00, 32'd0, 32'd0, 0);
        run_op("pass", 9, 2'b00, 4);
        check_bus("pass");

        mode = 2'b01; ip_selector = 2'd0; cur_src = 32'h5000; dst_base = 32'h2100;
        length = 5'd3; data_base = 32'h0; lfsr_seed = 32'd1;
        push_expect(3, 2'b01, 32'd1, 32'd0, 0);
        run_op("lfsr", 7, 2'b00, 3);
        check_bus("lfsr");

        ip_selector = 2'd3; cur_src = 32'h7000; dst_base = 32'h2180;
        length = 5'd2; data_base = 32'h11110000; lfsr_seed = 32'd0;
        push_expect(2, 2'b01, 32'd0, 32'd0, 0);
        run_op("lfsr_seed0", 5, 2'b00, 2);
        check_bus("lfsr_seed0");

        mode = 2'b10; ip_selector = 2'd2; cur_src = 32'h3000; dst_base = 32'h2400;
        length = 5'd4; data_base = 32'hA5000000;
        corner_index = 5'd2; corner_case_payload = 32'h63A91243;
        push_expect(4, 2'b10, 32'd0, 32'h63A91243, 2);
        run_op("corner2", 9, 2'b00, 4);
        check_bus("corner2");

        corner_index = 5'd7; dst_base = 32'h2500;
        push_expect(4, 2'b10, 32'd0, 32'h63A91243, 7);
        run_op("corner7", 9, 2'b00, 4);
        check_bus("corner7");

        mode = 2'b00; length = 5'd17;
        c0 = cyc_cnt;
        run_op("len_big", 0, 2'b01, 0);
        chk("len_big:no_bus", 32'(cyc_cnt), 32'(c0));

        mode = 2'b11; length = 5'd4;
        c0 = cyc_cnt;
        run_op("mode11", 0, 2'b01, 0);
        chk("mode11:no_bus", 32'(cyc_cnt), 32'(c0));

        mode = 2'b00; length = 5'd0;
        c0 = cyc_cnt;
        run_op("len0", 0, 2'b00, 0);
        chk("len0:no_bus", 32'(cyc_cnt), 32'(c0));
        check_bus("bad_cfg");

        ip_selector = 2'd1; cur_src = 32'h1000; dst_base = 32'h2600;
        length = 5'd4; data_base = 32'hC0DE0000;
        stall_en = 1'b1; stall_adr = 32'h1008;
        exp_rd_q.push_back(32'h1000);
        exp_rd_q.push_back(32'h1004);
        run_op("timeout", TO + 2, 2'b10, 2);
        check_bus("timeout");
        stall_en = 1'b0;

        length = 5'd3; dst_base = 32'h2200; data_base = 32'hD0000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort:in_write", 32'(wbm_we_o), 32'd1);
        chk("abort:words_pre", 32'(words_done), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort:cyc", 32'(wbm_cyc_o), 32'd0);
        chk("abort:done", 32'(done), 32'd1);
        chk("abort:status", 32'(status), 32'd3);
        chk("abort:words", 32'(words_done), 32'd1);
        chk("abort:first_wr_adr", (obs_wa_q.size() > wr_ptr) ? obs_wa_q[wr_ptr] : 32'hxxxxxxxx, 32'h2200);
        chk("abort:first_wr_dat", (obs_wd_q.size() > wr_ptr) ? obs_wd_q[wr_ptr] : 32'hxxxxxxxx, 32'hD0000000);
        @(negedge clk);
        chk("abort:busy_fall", 32'(busy), 32'd0);
        resync();

        length = 5'd2; dst_base = 32'h2300; data_base = 32'hE0000000;
        push_expect(2, 2'b00, 32'd0, 32'd0, 0);
        run_op("after_abort", 5, 2'b00, 2);
        check_bus("after_abort");

        length = 5'd8; data_base = 32'hF0000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:cyc", 32'(wbm_cyc_o), 32'd0);
        chk("midrst:stb", 32'(wbm_stb_o), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:words", 32'(words_done), 32'd0);
        chk("midrst:adr", wbm_adr_o, 32'd0);
        chk("midrst:status", 32'(status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        resync();

        length = 5'd1; dst_base = 32'h2700; data_base = 32'h12340000;
        push_expect(1, 2'b00, 32'd0, 32'd0, 0);
        run_op("after_rst", 3, 2'b00, 1);
        check_bus("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
